// File: rtl/bench_pkg.sv
// bench_pkg: mode encodings and default sizing shared by the benchmark output sequencer.
`default_nettype none

package bench_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_FREEZE = 2'b10,
        MODE_EVENTS = 2'b11
    } mode_e;

    localparam int DEFAULT_N_CH = 8;
    localparam int DEFAULT_W    = 8;

endpackage

`default_nettype wire

// File: rtl/event_counter.sv
// event_counter: rising-edge detector feeding a W-bit saturating counter with synchronous clear.
`default_nettype none

module event_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ev,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic prev;
    logic rise;

    // prev starts at 0, so a level already high after reset counts once
    assign rise = ev & ~prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev  <= 1'b0;
            count <= '0;
        end else begin
            prev <= ev;
            if (clear)
                count <= '0;
            else if (rise && (count != {W{1'b1}}))
                count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bench_output_sequencer.sv
// bench_output_sequencer: registered N_CH-way output selector with direct, auto-scan,
// freeze and event-count views.
`default_nettype none

module bench_output_sequencer
    import bench_pkg::*;
#(
    parameter int  N_CH     = DEFAULT_N_CH,
    parameter int  W        = DEFAULT_W,
    parameter int  SCAN_DIV = 1024,
    localparam int SEL_W    = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH*W-1:0] ch_data,
    input  logic [N_CH-1:0]   ch_event,
    input  logic [SEL_W-1:0]  sel,
    input  logic [1:0]        mode,
    input  logic              clear,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              scan_tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [W-1:0]     chans  [N_CH];
    logic [W-1:0]     counts [N_CH];

    logic [SEL_W-1:0] cur_ch, cur_nx, out_ch_nx;
    logic [DIV_W-1:0] div_cnt, div_nx;
    logic [1:0]       prev_mode;
    logic [W-1:0]     out_data_nx;
    logic             scan_tick_nx;
    logic             sel_ok;
    logic             scan_entry;
    logic             scan_wrap;

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_channel
            assign chans[k] = ch_data[k*W +: W];

            event_counter #(.W(W)) u_event_counter (
                .clk     (clk),
                .reset_n (reset_n),
                .ev      (ch_event[k]),
                .clear   (clear),
                .count   (counts[k])
            );
        end
    endgenerate

    assign sel_ok     = (int'(sel) < N_CH);
    // Any cycle in scan not preceded by a scan cycle (including the first after reset) is an entry
    assign scan_entry = (prev_mode != MODE_SCAN);
    assign scan_wrap  = (div_cnt == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        cur_nx       = cur_ch;
        div_nx       = div_cnt;
        out_ch_nx    = out_ch;
        out_data_nx  = out_data;
        scan_tick_nx = 1'b0;
        case (mode)
            MODE_DIRECT: begin
                out_ch_nx   = sel;
                out_data_nx = sel_ok ? chans[sel] : '0;
                div_nx      = '0;
            end
            MODE_SCAN: begin
                if (scan_entry) begin
                    cur_nx = sel_ok ? sel : '0;
                    div_nx = '0;
                end else if (scan_wrap) begin
                    div_nx       = '0;
                    cur_nx       = (cur_ch == SEL_W'(N_CH - 1)) ? '0 : cur_ch + 1'b1;
                    scan_tick_nx = 1'b1;
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
                // Show the channel being loaded this cycle so each one stays up SCAN_DIV cycles
                out_ch_nx   = cur_nx;
                out_data_nx = chans[cur_nx];
            end
            MODE_EVENTS: begin
                out_ch_nx   = sel;
                out_data_nx = sel_ok ? counts[sel] : '0;
                div_nx      = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_ch    <= '0;
            div_cnt   <= '0;
            prev_mode <= MODE_DIRECT;
            out_ch    <= '0;
            out_data  <= '0;
            scan_tick <= 1'b0;
        end else begin
            cur_ch    <= cur_nx;
            div_cnt   <= div_nx;
            prev_mode <= mode;
            out_ch    <= out_ch_nx;
            out_data  <= out_data_nx;
            scan_tick <= scan_tick_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bench_output_sequencer.sv
// tb_bench_output_sequencer: directed and randomized checks of bench_output_sequencer
// against a cycle-level behavioural model.
`timescale 1ns/1ps
`default_nettype none

module tb_bench_output_sequencer;

    localparam int N_CH     = 6;
    localparam int W        = 8;
    localparam int SCAN_DIV = 4;
    localparam int SEL_W    = $clog2(N_CH);
    localparam int DW       = N_CH * W;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [DW-1:0]    ch_data = '0;
    logic [N_CH-1:0]  ch_event = '0;
    logic [SEL_W-1:0] sel = '0;
    logic [1:0]       mode = 2'b00;
    logic             clear = 1'b0;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_ch;
    logic             scan_tick;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    bench_output_sequencer #(.N_CH(N_CH), .W(W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ch_data   (ch_data),
        .ch_event  (ch_event),
        .sel       (sel),
        .mode      (mode),
        .clear     (clear),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .scan_tick (scan_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_cnt [N_CH];
    bit           m_prev[N_CH];
    bit           m_scanning;
    int           m_entry_ch;
    int           m_n;            // cycles since scan entry
    logic [W-1:0]     exp_data;
    logic [SEL_W-1:0] exp_ch;
    bit               exp_tick;

    function automatic logic [W-1:0] chan(input int c);
        return ch_data[c*W +: W];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                m_cnt[i]  = 0;
                m_prev[i] = 1'b0;
            end
            m_scanning = 1'b0;
            m_entry_ch = 0;
            m_n        = 0;
            exp_data   = '0;
            exp_ch     = '0;
            exp_tick   = 1'b0;
        end else begin
            exp_tick = 1'b0;
            case (mode)
                2'b00: begin
                    exp_ch   = sel;
                    exp_data = (int'(sel) < N_CH) ? chan(int'(sel)) : '0;
                end
                2'b01: begin
                    if (!m_scanning) begin
                        m_entry_ch = (int'(sel) < N_CH) ? int'(sel) : 0;
                        m_n = 0;
                    end else begin
                        m_n++;
                    end
                    exp_ch   = SEL_W'((m_entry_ch + m_n / SCAN_DIV) % N_CH);
                    exp_data = chan(int'(exp_ch));
                    exp_tick = (m_n != 0) && (m_n % SCAN_DIV == 0);
                end
                2'b11: begin
                    exp_ch   = sel;
                    exp_data = (int'(sel) < N_CH) ? W'(m_cnt[int'(sel)]) : '0;
                end
                default: begin
                end
            endcase
            m_scanning = (mode == 2'b01);
            for (int i = 0; i < N_CH; i++) begin
                if (clear)
                    m_cnt[i] = 0;
                else if (ch_event[i] && !m_prev[i] && m_cnt[i] < (1 << W) - 1)
                    m_cnt[i]++;
                m_prev[i] = ch_event[i];
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("cyc_out_data",  32'(out_data),  32'(exp_data));
            check("cyc_out_ch",    32'(out_ch),    32'(exp_ch));
            check("cyc_scan_tick", 32'(scan_tick), 32'(exp_tick));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] v);
        ch_data[c*W +: W] = v;
    endtask

    logic [W-1:0]     frz_data;
    logic [SEL_W-1:0] frz_ch;
    int scan_exp_ch  [9] = '{4, 4, 4, 4, 5, 5, 5, 5, 0};
    bit scan_exp_tk  [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(out_data), 32'h0);
        check("reset_ch",   32'(out_ch),   32'h0);
        check("reset_tick", 32'(scan_tick), 32'h0);
        checking = 1'b1;
        reset_n  = 1'b1;

        // direct
        ch_data = DW'({$urandom(), $urandom()});
        set_ch(3, 8'hA5);
        sel = 3'd3; mode = 2'b00;
        step();
        check("direct_data", 32'(out_data), 32'hA5);
        check("direct_ch",   32'(out_ch),   32'd3);
        sel = 3'd7;
        step();
        check("direct_oor_data", 32'(out_data), 32'h0);
        check("direct_oor_ch",   32'(out_ch),   32'd7);

        // scan with wrap at N_CH-1; sel ignored after entry
        sel = 3'd4; mode = 2'b01;
        for (int i = 0; i < 9; i++) begin
            step();
            sel = 3'd1;
            check("scan_seq_ch",   32'(out_ch),    32'(scan_exp_ch[i]));
            check("scan_seq_tick", 32'(scan_tick), 32'(scan_exp_tk[i]));
        end

        // freeze mid-scan on channel 5
        mode = 2'b00; sel = 3'd5;
        step();
        mode = 2'b01;
        step();
        check("scan_entry5", 32'(out_ch), 32'd5);
        frz_data = out_data;
        frz_ch   = out_ch;
        mode = 2'b10;
        step();
        set_ch(5, ~frz_data);
        sel = 3'd2;
        repeat (3) step();
        check("freeze_data", 32'(out_data), 32'(frz_data));
        check("freeze_ch",   32'(out_ch),   32'(frz_ch));
        mode = 2'b01;
        repeat (4) step();
        check("rescan_hold", 32'(out_ch), 32'd2);
        step();
        check("rescan_adv",  32'(out_ch), 32'd3);

        // events: three single pulses plus one long pulse
        for (int i = 0; i < 3; i++) begin
            ch_event[2] = 1'b1; step();
            ch_event[2] = 1'b0; step();
        end
        ch_event[2] = 1'b1; repeat (5) step();
        ch_event[2] = 1'b0; step();
        mode = 2'b11; sel = 3'd2;
        step();
        check("event_count4", 32'(out_data), 32'd4);

        // saturation then clear colliding with an edge
        for (int i = 0; i < 260; i++) begin
            ch_event[1] = 1'b1; step();
            ch_event[1] = 1'b0; step();
        end
        sel = 3'd1;
        step();
        check("event_sat", 32'(out_data), 32'hFF);
        ch_event[1] = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        check("clear_wins", 32'(out_data), 32'h0);
        step();
        check("clear_prev_upd", 32'(out_data), 32'h0);

        // asynchronous reset during scan
        ch_event = '0;
        mode = 2'b01; sel = 3'd2;
        step();
        check("pre_reset_ch", 32'(out_ch), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_data", 32'(out_data), 32'h0);
        check("async_ch",   32'(out_ch),   32'h0);
        repeat (2) step();
        sel = 3'd3;
        reset_n = 1'b1;
        step();
        check("post_reset_scan", 32'(out_ch), 32'd3);

        // randomized phase, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            sel      = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
            ch_data  = DW'({$urandom(), $urandom()});
            ch_event = N_CH'($urandom());
            clear    = ($urandom_range(0, 31) == 0);
            step();
        end

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
